// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   rx_state_t         - receiver frame-tracking states
//   DATA_BITS_DEFAULT  - default word width (matches the transmitter)
//   OVERSAMPLE_DEFAULT - default baud_tick pulses per bit period
//   majority3()        - 2-of-3 vote used for the bit decision
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DATA_BITS_DEFAULT  = 7;
  localparam int OVERSAMPLE_DEFAULT = 16;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   rst_n - synchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output, two clk of latency
// Also used for cts on the transmit side.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-word holding register.
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   baud_tick   - one-cycle enable, OVERSAMPLE pulses per bit period
//   rx          - asynchronous serial input, idle high
//   rx_data     - holding-register contents (LSB-first assembled word)
//   rx_valid    - holding register full
//   rx_ready    - consumer takes rx_data when rx_valid & rx_ready
//   rts         - ready-to-send to the far end (~rx_valid)
//   framing_err - one-cycle pulse: stop bit sampled low
//   overrun_err - one-cycle pulse: frame finished while the register was full
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rts,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_MID_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_MID_P1 = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t              state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;      // rx_s at ticks MID-1 and MID
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   framing_err_q, framing_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   maj;
  logic                   commit;

  // Bit decision: the two stored samples plus the live one at tick MID+1.
  assign maj = majority3(samp_q[0], samp_q[1], rx_s);

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    samp_d        = samp_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = 1'b0;
    overrun_err_d = 1'b0;
    commit        = 1'b0;

    // Inside a frame every tick advances the oversample counter; the
    // power-of-two width makes it wrap at OVERSAMPLE-1 on its own.
    if (baud_tick && (state_q inside {START, DATA, STOP})) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      if (tick_cnt_q == T_MID_M1) samp_d[0] = rx_s;
      if (tick_cnt_q == T_MID)    samp_d[1] = rx_s;
    end

    case (state_q)
      WAIT_HIGH: begin
        // A line stuck low after a framing error must go high before
        // another start bit can be recognised.
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == T_MID_M1 && rx_s) begin
            state_d = IDLE;                      // glitch, not a start bit
          end else if (tick_cnt_q == T_LAST) begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            tick_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == T_MID_P1) begin
            // LSB arrives first, so new bits enter at the top and slide down.
            shift_d = DATA_BITS'({maj, shift_q} >> 1);
          end
          if (tick_cnt_q == T_LAST) begin
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Decide at mid stop bit rather than waiting for its end so a
        // slightly fast transmitter's next start edge is not missed.
        if (baud_tick && tick_cnt_q == T_MID_P1) begin
          if (maj) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end
      end
      default: state_d = WAIT_HIGH;
    endcase

    // Holding register: a commit may replace a word consumed on the same edge.
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= WAIT_HIGH;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      samp_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      samp_q        <= samp_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rts         = ~rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a scoreboard.
// The stimulus process pushes each word it expects to see loaded into the
// holding register; a monitor pops and compares whenever a new word appears.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DB = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rts;
  logic          framing_err;
  logic          overrun_err;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rts         (rts),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            fe_cnt = 0;
  int            oe_cnt = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] mon_exp;
  logic          prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: sample 1 ns after each rising edge. rx_ready only changes on
  // falling edges, so its value here is the one the DUT just saw.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid && (!prev_valid || rx_ready)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no word", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 32'(rx_data), 32'(mon_exp));
          $display("word %0h received (expected %0h)", rx_data, mon_exp);
        end
      end
      if (framing_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (framing_err && overrun_err) begin
        n_vec++;
        n_err++;
        $display("FAIL both_err_pulses: got 1/1, expected at most one");
      end
      prev_valid = rx_valid;
    end
  end

  // One oversample tick every 4 clk. mode 1: at this tick the commit of
  // word cd into an empty register must occur; mode 2: same, but the old
  // word is held and rx_ready is pulsed exactly on the commit edge.
  task automatic tick(input int mode, input logic [DB-1:0] cd);
    repeat (3) @(negedge clk);
    baud_tick = 1'b1;
    if (mode == 1) check("pre_commit_valid", 32'(rx_valid), 32'd0);
    if (mode == 2) begin
      check("pre_commit_held", 32'(rx_valid), 32'd1);
      rx_ready = 1'b1;
    end
    @(negedge clk);
    baud_tick = 1'b0;
    rx_ready  = 1'b0;
    if (mode == 1) begin
      check("commit_valid", 32'(rx_valid), 32'd1);
      check("commit_data", 32'(rx_data), 32'(cd));
      check("commit_rts", 32'(rts), 32'd0);
    end
    if (mode == 2) begin
      check("swap_valid", 32'(rx_valid), 32'd1);
      check("swap_data", 32'(rx_data), 32'(cd));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(0, '0);
  endtask

  // Start detection lands on the first tick of the start bit, so the
  // stop-bit decision (tick index 9) falls on the 11th tick of the stop bit.
  task automatic send_bit(input logic b, input int stop_mode, input logic [DB-1:0] cd);
    rx = b;
    for (int t = 1; t <= 16; t++) tick((t == 11) ? stop_mode : 0, cd);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_val, input int mode);
    send_bit(1'b0, 0, d);
    for (int i = 0; i < DB; i++) send_bit(d[i], 0, d);
    send_bit(stop_val, mode, d);
  endtask

  task automatic drain();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("drain_valid", 32'(rx_valid), 32'd0);
    check("drain_rts", 32'(rts), 32'd1);
  endtask

  initial begin
    logic [DB-1:0] part;
    part = 7'h5A;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_rts", 32'(rts), 32'd1);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_oerr", 32'(overrun_err), 32'd0);
    rst_n = 1'b1;
    ticks(20);

    // 1: clean frame, commit latency
    exp_q.push_back(7'h55);
    send_frame(7'h55, 1'b1, 1);
    rx = 1'b1;
    ticks(4);
    check("t1_ferr_cnt", 32'(fe_cnt), 32'd0);
    check("t1_oerr_cnt", 32'(oe_cnt), 32'd0);
    drain();
    check("t1_data_hold", 32'(rx_data), 32'h55);

    // 2: start-bit glitch is rejected, next frame fine
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(30);
    check("t2_no_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(7'h2A);
    send_frame(7'h2A, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    check("t2_valid", 32'(rx_valid), 32'd1);
    check("t2_ferr_cnt", 32'(fe_cnt), 32'd0);
    drain();

    // 3: framing error, line stuck low, then recovery
    send_frame(7'h7F, 1'b0, 0);
    ticks(16 * 20);
    check("t3_ferr_cnt", 32'(fe_cnt), 32'd1);
    check("t3_no_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    ticks(20);
    exp_q.push_back(7'h01);
    send_frame(7'h01, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    check("t3_valid", 32'(rx_valid), 32'd1);
    check("t3_ferr_cnt2", 32'(fe_cnt), 32'd1);
    drain();

    // 4: overrun, second word dropped
    exp_q.push_back(7'h12);
    send_frame(7'h12, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    send_frame(7'h34, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    check("t4_oerr_cnt", 32'(oe_cnt), 32'd1);
    check("t4_data", 32'(rx_data), 32'h12);
    check("t4_valid", 32'(rx_valid), 32'd1);
    drain();

    // 5: consume on the commit edge, no overrun
    exp_q.push_back(7'h12);
    send_frame(7'h12, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    exp_q.push_back(7'h34);
    send_frame(7'h34, 1'b1, 2);
    rx = 1'b1;
    ticks(4);
    check("t5_oerr_cnt", 32'(oe_cnt), 32'd1);
    check("t5_data", 32'(rx_data), 32'h34);
    drain();

    // 6: reset during data bit 3 while a word is held
    exp_q.push_back(7'h55);
    send_frame(7'h55, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    check("t6_held", 32'(rx_valid), 32'd1);
    send_bit(1'b0, 0, part);
    for (int i = 0; i < 3; i++) send_bit(part[i], 0, part);
    rx = part[3];
    ticks(5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'd0);
    check("t6_rst_rts", 32'(rts), 32'd1);
    check("t6_rst_ferr", 32'(framing_err), 32'd0);
    check("t6_rst_oerr", 32'(overrun_err), 32'd0);
    rst_n = 1'b1;
    rx = 1'b1;
    ticks(20);
    check("t6_no_err", 32'(fe_cnt + oe_cnt), 32'd2);
    exp_q.push_back(7'h3C);
    send_frame(7'h3C, 1'b1, 0);
    rx = 1'b1;
    ticks(4);
    check("t6_valid", 32'(rx_valid), 32'd1);
    drain();

    ticks(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_ferr_cnt", 32'(fe_cnt), 32'd1);
    check("final_oerr_cnt", 32'(oe_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
